// File: rtl/sha256_pkg.sv
// Shared constants and FSM encoding for the SHA-256 message front end.
// Used by the address generator, the vector builder and the top level.
package sha256_pkg;

  localparam int DEF_MSG_LENGTH     = 55;
  localparam int DEF_ADDR_WIDTH     = 16;
  localparam int DEF_TIMEOUT_CYCLES = 15;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE     = 2'd0;
  localparam state_t ST_READ     = 2'd1;
  localparam state_t ST_WAIT_VEC = 2'd2;
  localparam state_t ST_DONE     = 2'd3;

  // A one-byte message still needs a one-bit offset bus.
  function automatic int offset_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/msg_addr_gen_if.sv
// Byte-load link between msg_addr_gen (master) and the vector builder.
// enable frames a fetch; message_vector_complete closes it.
interface msg_addr_gen_if
  import sha256_pkg::*;
#(
  parameter int MSG_LENGTH = DEF_MSG_LENGTH
) ();

  localparam int MSG_AW = offset_width(MSG_LENGTH);

  logic              enable;
  logic [MSG_AW-1:0] msg_address;
  logic              address_read_complete;
  logic              message_vector_complete;

  modport master (
    output enable,
    output msg_address,
    output address_read_complete,
    input  message_vector_complete
  );

  modport slave (
    input  enable,
    input  msg_address,
    input  address_read_complete,
    output message_vector_complete
  );

endinterface

// File: rtl/msg_offset_counter.sv
// Byte offset counter 0..MSG_LENGTH-1, saturating at the last byte.
// Exposes the next value so the owner can register derived outputs.
module msg_offset_counter
  import sha256_pkg::*;
#(
  parameter int MSG_LENGTH = DEF_MSG_LENGTH,
  parameter int CW         = offset_width(MSG_LENGTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic [CW-1:0] count_next,
  output logic          last,
  output logic          last_next
);

  localparam logic [CW-1:0] MAX = CW'(MSG_LENGTH - 1);

  logic [CW-1:0] count_q;

  always_comb begin
    count_next = count_q;
    if (clear) begin
      count_next = '0;
    end else if (inc && (count_q != MAX)) begin
      count_next = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_next;
    end
  end

  assign count     = count_q;
  assign last      = (count_q == MAX);
  assign last_next = (count_next == MAX);

endmodule

// File: rtl/msg_addr_gen.sv
// SRAM read sequencer feeding the message-vector builder one byte per cycle.
// Optional WAIT_VEC watchdog enabled by defining MSG_ADDR_GEN_TIMEOUT_EN.
module msg_addr_gen
  import sha256_pkg::*;
#(
  parameter int MSG_LENGTH     = DEF_MSG_LENGTH,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic [ADDR_WIDTH-1:0] sram_address,
  output logic                  sram_read_en,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  msg_addr_gen_if.master        bld
);

  localparam int MSG_AW = offset_width(MSG_LENGTH);

  state_t state;
  state_t state_n;

  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] base_n;
  logic [ADDR_WIDTH-1:0] addr_q;

  logic rd_q;
  logic en_q;
  logic arc_q;
  logic done_q;

  logic              cnt_clear;
  logic              cnt_inc;
  logic [MSG_AW-1:0] cnt;
  logic [MSG_AW-1:0] cnt_next;
  logic              cnt_last;
  logic              cnt_last_n;
  logic              timeout;

  msg_offset_counter #(
    .MSG_LENGTH (MSG_LENGTH),
    .CW         (MSG_AW)
  ) u_cnt (
    .clock      (clock),
    .reset      (reset),
    .clear      (cnt_clear),
    .inc        (cnt_inc),
    .count      (cnt),
    .count_next (cnt_next),
    .last       (cnt_last),
    .last_next  (cnt_last_n)
  );

`ifdef MSG_ADDR_GEN_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WW-1:0] wait_q;
  logic          error_q;

  // wait_q counts cycles since the last read; 1 on the first WAIT_VEC cycle.
  assign timeout = (wait_q == WW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      wait_q  <= '0;
      error_q <= 1'b0;
    end else begin
      if (state != ST_WAIT_VEC) begin
        wait_q <= WW'(1);
      end else begin
        wait_q <= wait_q + 1'b1;
      end
      if ((state == ST_WAIT_VEC) && timeout &&
          !bld.message_vector_complete) begin
        error_q <= 1'b1;
      end
    end
  end

  assign error = error_q;
`else
  assign timeout = 1'b0;
  assign error   = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    cnt_clear = 1'b0;
    cnt_inc   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_n   = ST_READ;
          cnt_clear = 1'b1;
        end
      end
      ST_READ: begin
        if (cnt_last) begin
          state_n = ST_WAIT_VEC;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_WAIT_VEC: begin
        if (bld.message_vector_complete || timeout) begin
          state_n = ST_DONE;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  assign base_n = cnt_clear ? base_addr : base_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= ST_IDLE;
      base_q <= '0;
      addr_q <= '0;
      rd_q   <= 1'b0;
      en_q   <= 1'b0;
      arc_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      base_q <= base_n;
      rd_q   <= (state_n == ST_READ);
      en_q   <= (state_n != ST_IDLE);
      done_q <= (state_n == ST_DONE);
      // Raised together with the last address, held through DONE.
      arc_q  <= ((state_n == ST_READ) && cnt_last_n) ||
                (state_n == ST_WAIT_VEC) ||
                (state_n == ST_DONE);
      if (state_n == ST_IDLE) begin
        addr_q <= '0;
      end else if (state_n == ST_READ) begin
        addr_q <= base_n + ADDR_WIDTH'(cnt_next);
      end
    end
  end

  assign sram_address = addr_q;
  assign sram_read_en = rd_q;
  assign busy         = en_q;
  assign done         = done_q;

  assign bld.enable                = en_q;
  assign bld.msg_address           = en_q ? cnt : '0;
  assign bld.address_read_complete = arc_q;

endmodule
